// File: rtl/ifetch_pkg.sv
// Shared constants, the prefetch-queue entry layout and PC helpers for the RV32I fetch front end.
package ifetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = XLEN + INSTR_W;

  localparam logic [XLEN-1:0]    PC_INC           = 32'd4;
  localparam logic [INSTR_W-1:0] RV_NOP           = 32'h0000_0013;
  localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch queue holding {pc, instr} pairs, plus its overflow checker.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;

  // Extra pointer bit tells a full queue apart from an empty one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  always_comb begin
    rdata = mem_r[rd_ptr_r[AW-1:0]];
    count = wr_ptr_r - rd_ptr_r;
    full  = (count == DEPTH_W);
    empty = (wr_ptr_r == rd_ptr_r);
  end

endmodule

module fetch_fifo_checker (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic full
);

  // The fetch credit scheme must never push into a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited instruction-memory reads and queues the returned words.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               i_mem_req,
  output logic [XLEN-1:0]    i_mem_addr,
  input  logic [INSTR_W-1:0] i_mem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_r;
  logic            inflight_r;
  logic [XLEN-1:0] inflight_pc_r;
  logic            kill_r;

  logic [AW:0]     count_s;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic            req_s;
  logic [AW+1:0]   credit_s;
  fetch_entry_t    wr_entry_s;
  fetch_entry_t    rd_entry_s;

  // Slots already spoken for (queued plus in flight, minus the one leaving) bound new requests.
  always_comb begin
    out_valid  = !empty_s && !redirect_valid;
    pop_s      = out_valid && out_ready;
    credit_s   = {1'b0, count_s} + {{(AW+1){1'b0}}, inflight_r} - {{(AW+1){1'b0}}, pop_s};
    req_s      = rst_n && !redirect_valid && (credit_s < DEPTH_W);
    push_s     = inflight_r && !kill_r && !redirect_valid;
    wr_entry_s = '{pc: inflight_pc_r, instr: i_mem_rdata};
    i_mem_req  = req_s;
    i_mem_addr = fetch_pc_r;
    out_instr  = rd_entry_s.instr;
    out_pc     = rd_entry_s.pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      kill_r        <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_r <= align_pc(redirect_pc);
      inflight_r <= 1'b0;
      kill_r     <= inflight_r;
    end else begin
      kill_r     <= 1'b0;
      inflight_r <= req_s;
      if (req_s) begin
        fetch_pc_r    <= fetch_pc_r + PC_INC;
        inflight_pc_r <= fetch_pc_r;
      end else begin
        fetch_pc_r    <= fetch_pc_r;
        inflight_pc_r <= inflight_pc_r;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .wdata (wr_entry_s),
    .rdata (rd_entry_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  fetch_fifo_checker u_fifo_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .full  (full_s)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a one-cycle-latency memory returns word k = 0x1000_0000 + k at byte address 4k.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_mem_req;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_rdata = 32'h0000_0000;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        req2;
  logic [31:0] addr2;
  logic [31:0] rdata2 = 32'h0000_0000;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0000_0000;
  logic        ready2 = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .i_mem_req(i_mem_req), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .i_mem_req(req2), .i_mem_addr(addr2),
    .i_mem_rdata(rdata2), .redirect_valid(redirect2), .redirect_pc(redirect_pc2),
    .out_valid(valid2), .out_ready(ready2), .out_instr(instr2), .out_pc(pc2)
  );

  always @(posedge clk) begin
    if (i_mem_req) i_mem_rdata <= 32'h1000_0000 + (i_mem_addr >> 2);
    if (req2)      rdata2      <= 32'h1000_0000 + (addr2 >> 2);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 (first cycle after release).
  task automatic do_reset(input logic ready);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    out_ready      = ready;
    rst_n          = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    rst_n          = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({i_mem_req, out_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_req_valid: got %b required 00", {i_mem_req, out_valid});
    end
    checks++;
    if ({i_mem_addr, out_instr, out_pc} !== {32'h0000_0000, 32'h0000_0000, 32'h0000_0000}) begin
      errors++; $display("FAIL reset_values: addr %h instr %h pc %h required all zero", i_mem_addr, out_instr, out_pc);
    end
    checks++;
    if ({req2, addr2} !== {1'b0, 32'hFFFF_FFF8}) begin
      errors++; $display("FAIL reset_wrap_addr: got %b/%h required 0/fffffff8", req2, addr2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({i_mem_req, i_mem_addr, out_valid} !== {1'b1, 32'h0000_0000, 1'b0}) begin
      errors++; $display("FAIL reset_first_req: req %b addr %h valid %b required 1/00000000/0", i_mem_req, i_mem_addr, out_valid);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({i_mem_req, i_mem_addr} !== {1'b1, 32'(4 * c)}) begin
        errors++; $display("FAIL stream_req c%0d: req %b addr %h required 1/%h", c, i_mem_req, i_mem_addr, 32'(4 * c));
      end
      checks++;
      if (c < 2) begin
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL stream_early_valid c%0d: got %b required 0", c, out_valid);
        end
      end else if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * (c - 2)), 32'h1000_0000 + 32'(c - 2)}) begin
        errors++; $display("FAIL stream_out c%0d: valid %b pc %h instr %h required 1/%h/%h",
                           c, out_valid, out_pc, out_instr, 32'(4 * (c - 2)), 32'h1000_0000 + 32'(c - 2));
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (c < 4) begin
        if ({i_mem_req, i_mem_addr} !== {1'b1, 32'(4 * c)}) begin
          errors++; $display("FAIL stall_req c%0d: req %b addr %h required 1/%h", c, i_mem_req, i_mem_addr, 32'(4 * c));
        end
      end else if (i_mem_req !== 1'b0) begin
        errors++; $display("FAIL stall_req_stop c%0d: req %b required 0", c, i_mem_req);
      end
      if (c >= 2) begin
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0000_0000, 32'h1000_0000}) begin
          errors++; $display("FAIL stall_head c%0d: valid %b pc %h instr %h required 1/00000000/10000000", c, out_valid, out_pc, out_instr);
        end
      end
      step();
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if ({i_mem_req, i_mem_addr, out_valid, out_pc} !== {1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000}) begin
      errors++; $display("FAIL stall_resume: req %b addr %h valid %b pc %h required 1/00000010/1/00000000", i_mem_req, i_mem_addr, out_valid, out_pc);
    end
    for (int k = 1; k < 5; k++) begin
      step();
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k)}) begin
        errors++; $display("FAIL stall_drain k%0d: valid %b pc %h instr %h required 1/%h/%h", k, out_valid, out_pc, out_instr, 32'(4 * k), 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step(); step(); step();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    #1;
    checks++;
    if ({i_mem_req, out_valid} !== 2'b00) begin
      errors++; $display("FAIL redirect_cycle: req/valid %b required 00", {i_mem_req, out_valid});
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #1;
    checks++;
    if ({i_mem_req, i_mem_addr, out_valid} !== {1'b1, 32'h0000_0200, 1'b0}) begin
      errors++; $display("FAIL redirect_target_req: req %b addr %h valid %b required 1/00000200/0", i_mem_req, i_mem_addr, out_valid);
    end
    step();
    checks++;
    if ({out_valid, i_mem_addr} !== {1'b0, 32'h0000_0204}) begin
      errors++; $display("FAIL redirect_gap: valid %b addr %h required 0/00000204", out_valid, i_mem_addr);
    end
    step();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0000_0200, 32'h1000_0080}) begin
      errors++; $display("FAIL redirect_first_out: valid %b pc %h instr %h required 1/00000200/10000080", out_valid, out_pc, out_instr);
    end
    step();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0000_0204, 32'h1000_0081}) begin
      errors++; $display("FAIL redirect_second_out: valid %b pc %h instr %h required 1/00000204/10000081", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    step(); step();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    checks++;
    if ({i_mem_req, out_valid} !== 2'b00) begin
      errors++; $display("FAIL b2b_first: req/valid %b required 00", {i_mem_req, out_valid});
    end
    @(negedge clk);
    redirect_pc = 32'h0000_0300;
    #1;
    checks++;
    if ({i_mem_req, out_valid} !== 2'b00) begin
      errors++; $display("FAIL b2b_second: req/valid %b required 00", {i_mem_req, out_valid});
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({i_mem_req, i_mem_addr, out_valid} !== {1'b1, 32'h0000_0300, 1'b0}) begin
      errors++; $display("FAIL b2b_target: req %b addr %h valid %b required 1/00000300/0", i_mem_req, i_mem_addr, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: valid %b required 0", out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0000_0300 + 32'(4 * k), 32'h1000_00C0 + 32'(k)}) begin
        errors++; $display("FAIL b2b_out k%0d: valid %b pc %h instr %h required 1/%h/%h",
                           k, out_valid, out_pc, out_instr, 32'h0000_0300 + 32'(4 * k), 32'h1000_00C0 + 32'(k));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr;
    do_reset(1'b1);
    for (int c = 0; c < 5; c++) begin
      exp_addr = 32'hFFFF_FFF8 + 32'(4 * c);
      checks++;
      if ({req2, addr2} !== {1'b1, exp_addr}) begin
        errors++; $display("FAIL wrap_req c%0d: req %b addr %h required 1/%h", c, req2, addr2, exp_addr);
      end
      if (c >= 2) begin
        exp_addr = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
        checks++;
        if ({valid2, pc2} !== {1'b1, exp_addr}) begin
          errors++; $display("FAIL wrap_out c%0d: valid %b pc %h required 1/%h", c, valid2, pc2, exp_addr);
        end
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    step(); step(); step();
    checks++;
    if ({i_mem_req, out_valid} !== 2'b11) begin
      errors++; $display("FAIL areset_busy: req/valid %b required 11", {i_mem_req, out_valid});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i_mem_req, out_valid, i_mem_addr} !== {2'b00, 32'h0000_0000}) begin
      errors++; $display("FAIL areset_drop: req/valid %b addr %h required 00/00000000", {i_mem_req, out_valid}, i_mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({i_mem_req, i_mem_addr, out_valid} !== {1'b1, 32'h0000_0000, 1'b0}) begin
      errors++; $display("FAIL areset_restart: req %b addr %h valid %b required 1/00000000/0", i_mem_req, i_mem_addr, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_no_stale: valid %b required 0", out_valid);
    end
    step();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0000_0000, 32'h1000_0000}) begin
      errors++; $display("FAIL areset_first_out: valid %b pc %h instr %h required 1/00000000/10000000", out_valid, out_pc, out_instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
